ir_prefetch_queue: RTL and testbench
====================================

Name: ir_prefetch_queue

Overview:
- Parametrised successor to the single-entry instruction register.
- Buffers up to DEPTH fetched instruction words ahead of the instruction register (IR) stage, with a valid/ready write handshake, a consume/advance strobe, and a pipeline flush.
- Also provides the current instruction's immediate, extended to the full word width.
- Sits between instruction memory fetch and the decoder/controller FSM.

Parameters:
- WIDTH, 16, instruction word width in bits; must be ≥ 8.
- DEPTH, 4, prefetch FIFO entries, not counting the IR itself; power of 2, ≥ 2.
- IMM_BITS, 8, width of the immediate field, taken from ir[IMM_BITS-1:0].
- SIGN_EXT, 1, 1 = sign-extend the immediate; 0 = zero-extend it.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  fetch presents a word.
- wr_data  in  WIDTH  fetched instruction word.
- wr_ready  out  1  queue accepts the word; equals !full.
- advance  in  1  decoder consumes the current IR.
- flush  in  1  discard the IR and all queued words (branch/jump taken).
- ir_valid  out  1  ir holds a live instruction.
- ir  out  WIDTH  current instruction register.
- imm_ext  out  WIDTH  extended immediate of ir; combinational from ir.
- count  out  $clog2(DEPTH+1)  number of FIFO entries occupied, excluding the IR.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (asynchronous, active-high; wins over every other input):
  - ir = 0, ir_valid = 0, count = 0.
  - Read and write pointers = 0; empty = 1, full = 0, wr_ready = 1.
  - imm_ext = 0.
- Push: occurs when wr_valid && wr_ready. wr_ready depends only on registered state and never combinationally on wr_valid or advance.
- IR load condition (load_ok): !ir_valid || advance.
- Per cycle, when not flushing:
  - load_ok and FIFO non-empty: ir <= head entry, ir_valid <= 1, pop.
  - load_ok, FIFO empty, push this cycle: bypass. ir <= wr_data, ir_valid <= 1; the FIFO is not written and count is unchanged. Fetch-to-IR latency is 1 cycle.
  - load_ok, FIFO empty, no push: ir_valid <= 0 and ir holds its old value.
  - !load_ok: ir and ir_valid hold.
  - A push not consumed by the bypass is written at the tail.
  - count changes by +1 for push only, -1 for pop only, and 0 when both happen.
- Write while full: wr_ready = 0, so the word is not accepted even if advance pops in the same cycle. The fetch unit holds wr_data until it sees wr_ready.
- advance while ir_valid = 0: ignored, no error.
- FIFO ordering: strictly first-in first-out. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Flush (synchronous; highest priority after reset):
  - Next edge: ir_valid = 0, count = 0, pointers reset to 0, ir holds its value.
  - A push presented in the flush cycle is dropped, even though wr_ready may be 1.
  - advance in the same cycle has no effect.
- imm_ext:
  - SIGN_EXT = 1: {(WIDTH-IMM_BITS) copies of ir[IMM_BITS-1], ir[IMM_BITS-1:0]}.
  - SIGN_EXT = 0: zero-filled upper bits.
  - imm_ext is driven regardless of ir_valid.
- No combinational path from wr_data to ir or imm_ext. All outputs except imm_ext and wr_ready/empty/full (decodes of count) are registered.

Decomposition:
- Shared package cpu_pkg:
  - WORD_WIDTH = 16, IMM_BITS = 8.
  - Opcode field positions OPC_MSB/LSB = 15/12.
  - Helper function sext_imm(word, bits).
- Sub-module: ir_fifo_mem (DEPTH × WIDTH register array, one write port, one async read port, no reset on the data array).
- Pointer/count control, bypass, flush and the IR register stay in ir_prefetch_queue.

Test Plan:
1. Reset mid-stream: push 0x1234, 0x5678, assert reset between clock edges -> ir = 0, ir_valid = 0, count = 0 immediately, before the next clk edge.
2. Bypass: empty queue, push 0xA0F3 with no advance -> next edge ir = 0xA0F3, ir_valid = 1, count = 0, imm_ext = 0xFFF3 (SIGN_EXT=1); rerun with SIGN_EXT=0 -> imm_ext = 0x00F3.
3. Fill and order: with ir_valid = 1 and no advance, push 0x1001..0x1004 -> count = 4, full = 1, wr_ready = 0. A 5th word, 0x1005, is held off. Pulse advance 4 times -> ir sequence 0x1001..0x1004, then 0x1005 enters after wr_ready rises.
4. Simultaneous push and advance at count = 2 -> count stays 2, ir takes the head entry, and the new word lands at the tail; pointers wrap correctly after 10 such cycles with DEPTH = 4.
5. Flush with push in the same cycle at count = 3 -> next edge count = 0, empty = 1, ir_valid = 0, and the pushed word is absent from the following reads.
6. advance with ir_valid = 0 and empty queue -> no state change, count stays 0, no underflow.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word geometry, opcode field position and immediate helper.
package cpu_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int IMM_BITS   = 8;
    localparam int OPC_MSB    = 15;
    localparam int OPC_LSB    = 12;

    // Sign-extend the low 'bits' bits of a word to the full word width.
    function automatic logic [WORD_WIDTH-1:0] sext_imm(input logic [WORD_WIDTH-1:0] word,
                                                       input int bits);
        logic [WORD_WIDTH-1:0] res;
        logic                  sgn;
        sgn = word[4'(bits - 1)];
        for (int i = 0; i < WORD_WIDTH; i++) begin
            res[i] = (i < bits) ? word[i] : sgn;
        end
        return res;
    endfunction

endpackage

// File: rtl/ir_prefetch_queue_if.sv
// Fetch/decode side signal bundle of the prefetch queue.
interface ir_prefetch_queue_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic            wr_ready;
    logic            advance;
    logic            flush;
    logic            ir_valid;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] imm_ext;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;

    // Fetch unit and decoder drive the queue.
    modport master (
        output wr_valid, wr_data, advance, flush,
        input  wr_ready, ir_valid, ir, imm_ext, count, empty, full
    );

    // The queue itself.
    modport slave (
        input  wr_valid, wr_data, advance, flush,
        output wr_ready, ir_valid, ir, imm_ext, count, empty, full
    );
endinterface

// File: rtl/ir_fifo_mem.sv
// Prefetch storage: DEPTH x WIDTH register array, one write port, one async read port.
module ir_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    import cpu_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming word; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction prefetch queue: DEPTH-word FIFO in front of the instruction register,
// with empty-queue bypass, flush and immediate extension of the current instruction.
module ir_prefetch_queue #(
    parameter int WIDTH    = cpu_pkg::WORD_WIDTH,
    parameter int DEPTH    = 4,
    parameter int IMM_BITS = cpu_pkg::IMM_BITS,
    parameter int SIGN_EXT = 1
) (
    input  logic                clk,
    input  logic                reset,
    ir_prefetch_queue_if.slave  bus
);
    import cpu_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] ir_r;
    logic             ir_valid_r;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] imm_c;

    logic full_c;
    logic empty_c;
    logic push;
    logic load_ok;
    logic pop;
    logic bypass;
    logic fifo_wr;

    // Status decodes come from registered count only, so wr_ready never
    // depends combinationally on wr_valid or advance.
    assign full_c  = (count_r == CW'(DEPTH));
    assign empty_c = (count_r == '0);

    assign push    = bus.wr_valid && !full_c;
    assign load_ok = !ir_valid_r || bus.advance;
    assign pop     = !bus.flush && load_ok && !empty_c;
    assign bypass  = !bus.flush && load_ok && empty_c && push;
    assign fifo_wr = !bus.flush && push && !bypass;

    ir_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (fifo_wr),
        .waddr (wr_ptr),
        .wdata (bus.wr_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Pointer and occupancy bookkeeping; flush empties the queue in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Instruction register: load from the head, or straight from fetch when the
    // queue is empty; ir keeps its stale value whenever it goes invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_r       <= '0;
            ir_valid_r <= 1'b0;
        end else if (bus.flush) begin
            ir_valid_r <= 1'b0;
        end else if (load_ok) begin
            if (!empty_c) begin
                ir_r       <= head;
                ir_valid_r <= 1'b1;
            end else if (push) begin
                ir_r       <= bus.wr_data;
                ir_valid_r <= 1'b1;
            end else begin
                ir_valid_r <= 1'b0;
            end
        end
    end

    // Immediate of the current instruction, widened to a full word.
    always_comb begin
        imm_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i < IMM_BITS)
                imm_c[i] = ir_r[i];
            else
                imm_c[i] = (SIGN_EXT != 0) ? ir_r[IMM_BITS-1] : 1'b0;
        end
    end

    assign bus.wr_ready = !full_c;
    assign bus.full     = full_c;
    assign bus.empty    = empty_c;
    assign bus.count    = count_r;
    assign bus.ir       = ir_r;
    assign bus.ir_valid = ir_valid_r;
    assign bus.imm_ext  = imm_c;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: directed vector table, reset corner and random traffic
// against a queue-based reference model. Two DUTs differ only in SIGN_EXT.
module tb_ir_prefetch_queue;

    localparam int W = 16;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ir_prefetch_queue_if #(.WIDTH(W), .DEPTH(D)) bus_s ();
    ir_prefetch_queue_if #(.WIDTH(W), .DEPTH(D)) bus_z ();

    ir_prefetch_queue #(.WIDTH(W), .DEPTH(D), .IMM_BITS(8), .SIGN_EXT(1)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    ir_prefetch_queue #(.WIDTH(W), .DEPTH(D), .IMM_BITS(8), .SIGN_EXT(0)) dut_z (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_z.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: queued words, IR contents and IR validity.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_ir;
    bit           m_irv;

    typedef struct {
        bit           wv;
        logic [W-1:0] wd;
        bit           adv;
        bit           fl;
        logic [W-1:0] e_ir;
        bit           e_irv;
        int           e_cnt;
    } row_t;

    row_t rows[24];

    function automatic row_t mk(bit wv, logic [W-1:0] wd, bit adv, bit fl,
                                logic [W-1:0] e_ir, bit e_irv, int e_cnt);
        row_t r;
        r.wv = wv; r.wd = wd; r.adv = adv; r.fl = fl;
        r.e_ir = e_ir; r.e_irv = e_irv; r.e_cnt = e_cnt;
        return r;
    endfunction

    function automatic logic [W-1:0] imm_exp(logic [W-1:0] word, bit sx);
        logic [7:0] lo;
        lo = word[7:0];
        if (sx && lo[7]) return 16'hFF00 | {8'h00, lo};
        return {8'h00, lo};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ir  = '0;
        m_irv = 1'b0;
    endtask

    task automatic model_step(bit wv, logic [W-1:0] wd, bit adv, bit fl);
        bit taken;
        bit consumed;
        taken    = wv && (mq.size() < D);
        consumed = 1'b0;
        if (fl) begin
            mq.delete();
            m_irv = 1'b0;
        end else begin
            if (!m_irv || adv) begin
                if (mq.size() > 0) begin
                    m_ir  = mq.pop_front();
                    m_irv = 1'b1;
                end else if (taken) begin
                    m_ir     = wd;
                    m_irv    = 1'b1;
                    consumed = 1'b1;
                end else begin
                    m_irv = 1'b0;
                end
            end
            if (taken && !consumed) mq.push_back(wd);
        end
    endtask

    task automatic compare_all(string tag);
        chk({tag, ".ir"},       32'(bus_s.ir),       32'(m_ir));
        chk({tag, ".ir_valid"}, 32'(bus_s.ir_valid), 32'(m_irv));
        chk({tag, ".count"},    32'(bus_s.count),    32'(mq.size()));
        chk({tag, ".empty"},    32'(bus_s.empty),    32'(mq.size() == 0));
        chk({tag, ".full"},     32'(bus_s.full),     32'(mq.size() == D));
        chk({tag, ".imm_sx"},   32'(bus_s.imm_ext),  32'(imm_exp(m_ir, 1'b1)));
        chk({tag, ".imm_zx"},   32'(bus_z.imm_ext),  32'(imm_exp(m_ir, 1'b0)));
        chk({tag, ".ir_z"},     32'(bus_z.ir),       32'(m_ir));
    endtask

    task automatic drive(bit wv, logic [W-1:0] wd, bit adv, bit fl);
        bus_s.wr_valid = wv; bus_s.wr_data = wd; bus_s.advance = adv; bus_s.flush = fl;
        bus_z.wr_valid = wv; bus_z.wr_data = wd; bus_z.advance = adv; bus_z.flush = fl;
    endtask

    task automatic step(bit wv, logic [W-1:0] wd, bit adv, bit fl, string tag);
        @(negedge clk);
        drive(wv, wd, adv, fl);
        chk({tag, ".wr_ready"}, 32'(bus_s.wr_ready), 32'(mq.size() < D));
        @(posedge clk);
        model_step(wv, wd, adv, fl);
        #1;
        compare_all(tag);
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        model_reset();

        // Directed table: bypass, fill/order, push+advance wrap, flush, idle advance.
        rows[0] = mk(0, 16'h0000, 1, 0, 16'h0000, 0, 0);
        rows[1] = mk(1, 16'hA0F3, 0, 0, 16'hA0F3, 1, 0);
        for (int i = 0; i < 4; i++)
            rows[2 + i] = mk(1, 16'h1001 + 16'(i), 0, 0, 16'hA0F3, 1, i + 1);
        rows[6] = mk(1, 16'h1005, 0, 0, 16'hA0F3, 1, 4);
        rows[7] = mk(1, 16'h1005, 1, 0, 16'h1001, 1, 3);
        rows[8] = mk(1, 16'h1005, 1, 0, 16'h1002, 1, 3);
        rows[9] = mk(0, 16'h0000, 1, 0, 16'h1003, 1, 2);
        for (int k = 0; k < 10; k++) begin
            logic [W-1:0] e;
            e = (k == 0) ? 16'h1004 : (k == 1) ? 16'h1005 : 16'h2001 + 16'(k - 2);
            rows[10 + k] = mk(1, 16'h2001 + 16'(k), 1, 0, e, 1, 2);
        end
        rows[20] = mk(1, 16'h3001, 0, 0, 16'h2008, 1, 3);
        rows[21] = mk(1, 16'h3002, 1, 1, 16'h2008, 0, 0);
        rows[22] = mk(0, 16'h0000, 1, 0, 16'h2008, 0, 0);
        rows[23] = mk(1, 16'h4001, 0, 0, 16'h4001, 1, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        chk("reset.wr_ready", 32'(bus_s.wr_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Reset arriving between edges clears state immediately.
        step(1, 16'h1234, 0, 0, "mid");
        step(1, 16'h5678, 0, 0, "mid");
        chk("mid.pre_count", 32'(bus_s.count), 32'd1);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async.ir",       32'(bus_s.ir),       32'h0);
        chk("async.ir_valid", 32'(bus_s.ir_valid), 32'h0);
        chk("async.count",    32'(bus_s.count),    32'h0);
        chk("async.empty",    32'(bus_s.empty),    32'h1);
        chk("async.imm",      32'(bus_s.imm_ext),  32'h0);
        @(negedge clk);
        reset = 1'b0;

        foreach (rows[i]) begin
            step(rows[i].wv, rows[i].wd, rows[i].adv, rows[i].fl, $sformatf("row%0d", i));
            chk($sformatf("row%0d.tbl_ir", i),    32'(bus_s.ir),       32'(rows[i].e_ir));
            chk($sformatf("row%0d.tbl_irv", i),   32'(bus_s.ir_valid), 32'(rows[i].e_irv));
            chk($sformatf("row%0d.tbl_count", i), 32'(bus_s.count),    32'(rows[i].e_cnt));
        end
        chk("bypass.imm_sx", 32'(imm_exp(16'hA0F3, 1'b1)), 32'hFFF3);

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            bit           wv;
            bit           adv;
            bit           fl;
            logic [W-1:0] wd;
            wv  = ($urandom_range(0, 9) < 7);
            adv = ($urandom_range(0, 1) == 1);
            fl  = ($urandom_range(0, 24) == 0);
            wd  = 16'($urandom);
            step(wv, wd, adv, fl, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
